// File: rtl/dma_pkg.sv
// Shared DMA definitions: link-list FSM states, descriptor word layout and CTRL bits.
package dma_pkg;

    localparam int DESC_WORDS_DEF = 6;

    localparam int W_SRC  = 0;
    localparam int W_DST  = 1;
    localparam int W_LEN  = 2;
    localparam int W_NEXT = 3;
    localparam int W_CTRL = 4;
    localparam int W_RSVD = 5;

    localparam int CTRL_LAST   = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [2:0] {
        LL_IDLE,
        LL_REQ,
        LL_DATA,
        LL_ISSUE,
        LL_WAIT
    } ll_state_e;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ll_desc_asm.sv
// Descriptor beat assembler: counts link data beats, captures the kept descriptor
// words and flags beats that arrive while no descriptor is being fetched.
module ll_desc_asm
    import dma_pkg::*;
#(
    parameter int DW         = 32,
    parameter int DESC_WORDS = DESC_WORDS_DEF,
    parameter int CNT_W      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          capture,
    input  logic          guard,
    input  logic          ll_dvld,
    input  logic [DW-1:0] ll_rdata,
    output logic          last_beat,
    output logic          overrun,
    output logic [DW-1:0] word_src,
    output logic [DW-1:0] word_dst,
    output logic [DW-1:0] word_len,
    output logic [DW-1:0] word_next,
    output logic [DW-1:0] word_ctrl
);

    logic [CNT_W-1:0] count;
    logic             beat;

    assign beat      = capture && ll_dvld;
    assign last_beat = beat && (count == CNT_W'(DESC_WORDS - 1));
    assign overrun   = guard && ll_dvld;

    // The reserved word still advances the count but is never stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            word_src  <= '0;
            word_dst  <= '0;
            word_len  <= '0;
            word_next <= '0;
            word_ctrl <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (beat) begin
            count <= count + CNT_W'(1);
            case (count)
                CNT_W'(W_SRC):  word_src  <= ll_rdata;
                CNT_W'(W_DST):  word_dst  <= ll_rdata;
                CNT_W'(W_LEN):  word_len  <= ll_rdata;
                CNT_W'(W_NEXT): word_next <= ll_rdata;
                CNT_W'(W_CTRL): word_ctrl <= ll_rdata;
                CNT_W'(W_RSVD): ;
                default:        ;
            endcase
        end
    end

endmodule

// File: rtl/ll_desc_ctrl.sv
// Link-list descriptor controller: fetches each descriptor of a chain, hands it to the
// channel engine and follows NEXT_PTR until LAST, a bad pointer or abort.
module ll_desc_ctrl
    import dma_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int DESC_WORDS = DESC_WORDS_DEF,
    parameter int CNT_W      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] head_ptr,
    input  logic          abort,
    output logic          ll_req,
    output logic [AW-1:0] ll_addr,
    input  logic          ll_ack,
    input  logic          ll_dvld,
    input  logic [DW-1:0] ll_rdata,
    output logic          desc_vld,
    input  logic          desc_rdy,
    output logic [AW-1:0] desc_src,
    output logic [AW-1:0] desc_dst,
    output logic [DW-1:0] desc_len,
    output logic [DW-1:0] desc_ctrl,
    input  logic          xfer_done,
    output logic          busy,
    output logic          chain_done,
    output logic          irq,
    output logic          err
);

    ll_state_e     state, state_nxt;
    logic [AW-1:0] addr_q;
    logic          abort_pend;
    logic          load_head, load_next, ack_take, fsm_err;
    logic          capture, guard, last_beat, overrun;
    logic [DW-1:0] word_src, word_dst, word_len, word_next, word_ctrl;

    assign capture = (state == LL_DATA);
    assign guard   = (state == LL_IDLE) || (state == LL_ISSUE) || (state == LL_WAIT);

    ll_desc_asm #(
        .DW         (DW),
        .DESC_WORDS (DESC_WORDS),
        .CNT_W      (CNT_W)
    ) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (ack_take),
        .capture   (capture),
        .guard     (guard),
        .ll_dvld   (ll_dvld),
        .ll_rdata  (ll_rdata),
        .last_beat (last_beat),
        .overrun   (overrun),
        .word_src  (word_src),
        .word_dst  (word_dst),
        .word_len  (word_len),
        .word_next (word_next),
        .word_ctrl (word_ctrl)
    );

    assign ll_addr   = addr_q;
    assign desc_src  = AW'(word_src);
    assign desc_dst  = AW'(word_dst);
    assign desc_len  = word_len;
    assign desc_ctrl = word_ctrl;
    assign busy      = (state != LL_IDLE);
    assign err       = (fsm_err || overrun) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LL_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (load_head) begin
            addr_q <= head_ptr;
        end else if (load_next) begin
            addr_q <= AW'(word_next);
        end
    end

    // An abort seen while the fetch is outstanding is remembered until the beats drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_pend <= 1'b0;
        end else if ((state == LL_REQ) || (state == LL_DATA)) begin
            abort_pend <= abort_pend || abort;
        end else begin
            abort_pend <= 1'b0;
        end
    end

    always_comb begin
        state_nxt  = state;
        ll_req     = 1'b0;
        desc_vld   = 1'b0;
        chain_done = 1'b0;
        irq        = 1'b0;
        fsm_err    = 1'b0;
        load_head  = 1'b0;
        load_next  = 1'b0;
        ack_take   = 1'b0;
        case (state)
            LL_IDLE: begin
                if (start) begin
                    if (misaligned(head_ptr[1:0])) begin
                        fsm_err = 1'b1;
                    end else begin
                        load_head = 1'b1;
                        state_nxt = LL_REQ;
                    end
                end
            end
            LL_REQ: begin
                ll_req = 1'b1;
                if (ll_ack) begin
                    ack_take  = 1'b1;
                    state_nxt = LL_DATA;
                end
            end
            LL_DATA: begin
                if (last_beat) begin
                    if (abort_pend || abort) begin
                        chain_done = 1'b1;
                        state_nxt  = LL_IDLE;
                    end else begin
                        state_nxt = LL_ISSUE;
                    end
                end
            end
            LL_ISSUE: begin
                desc_vld = 1'b1;
                if (desc_rdy) begin
                    state_nxt = LL_WAIT;
                end else if (abort) begin
                    chain_done = 1'b1;
                    state_nxt  = LL_IDLE;
                end
            end
            LL_WAIT: begin
                if (xfer_done) begin
                    irq = word_ctrl[CTRL_IRQ_EN];
                    if (word_ctrl[CTRL_LAST] || abort) begin
                        chain_done = 1'b1;
                        state_nxt  = LL_IDLE;
                    end else if ((word_next == '0) || misaligned(word_next[1:0])) begin
                        fsm_err   = 1'b1;
                        state_nxt = LL_IDLE;
                    end else begin
                        load_next = 1'b1;
                        state_nxt = LL_REQ;
                    end
                end
            end
            default: state_nxt = LL_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ll_desc_ctrl.sv
// Self-checking bench for ll_desc_ctrl: a descriptor memory and bus responder drive the
// DUT while a chain-walk model predicts addresses, descriptors, pulses and outcome.
module tb_ll_desc_ctrl;

    localparam int AB_NONE  = 0;
    localparam int AB_DATA  = 1;
    localparam int AB_ISSUE = 2;
    localparam int AB_WAIT  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] head_ptr = '0;
    logic        abort = 1'b0;
    logic        ll_req;
    logic [31:0] ll_addr;
    logic        ll_ack = 1'b0;
    logic        ll_dvld = 1'b0;
    logic [31:0] ll_rdata = '0;
    logic        desc_vld;
    logic        desc_rdy = 1'b0;
    logic [31:0] desc_src, desc_dst, desc_len, desc_ctrl;
    logic        xfer_done = 1'b0;
    logic        busy, chain_done, irq, err;

    int checks = 0;
    int errors = 0;

    logic [5:0][31:0] mem [logic [31:0]];
    logic [31:0]      expAddr [$];
    int               expHs, expIrq, expDone, expErr;

    ll_desc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .head_ptr   (head_ptr),
        .abort      (abort),
        .ll_req     (ll_req),
        .ll_addr    (ll_addr),
        .ll_ack     (ll_ack),
        .ll_dvld    (ll_dvld),
        .ll_rdata   (ll_rdata),
        .desc_vld   (desc_vld),
        .desc_rdy   (desc_rdy),
        .desc_src   (desc_src),
        .desc_dst   (desc_dst),
        .desc_len   (desc_len),
        .desc_ctrl  (desc_ctrl),
        .xfer_done  (xfer_done),
        .busy       (busy),
        .chain_done (chain_done),
        .irq        (irq),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setDesc(input logic [31:0] a, input logic [31:0] src, input logic [31:0] dst,
                           input logic [31:0] len, input logic [31:0] nxt, input logic [31:0] ctrl);
        logic [5:0][31:0] w;
        w[0] = src;
        w[1] = dst;
        w[2] = len;
        w[3] = nxt;
        w[4] = ctrl;
        w[5] = $urandom;
        mem[a] = w;
    endtask

    // Walk the chain in memory the way the spec describes it and record the outcome.
    function automatic void buildModel(input logic [31:0] head, input int kind, input int at);
        logic [31:0]      a;
        logic [5:0][31:0] w;
        expAddr.delete();
        expHs = 0;
        expIrq = 0;
        expDone = 0;
        expErr = 0;
        if (head % 4 != 0) begin
            expErr = 1;
            return;
        end
        a = head;
        for (int i = 0; i < 16; i++) begin
            expAddr.push_back(a);
            w = mem[a];
            if ((kind == AB_DATA || kind == AB_ISSUE) && i == at) begin
                expDone = 1;
                return;
            end
            expHs++;
            if (w[4][1]) expIrq++;
            if (w[4][0] || (kind == AB_WAIT && i == at)) begin
                expDone = 1;
                return;
            end
            if (w[3] == 0 || w[3] % 4 != 0) begin
                expErr = 1;
                return;
            end
            a = w[3];
        end
    endfunction

    task automatic applyStimulus(input logic [31:0] head, input int kind, input int at,
                                 input bit bp, input bit extras);
        int               cyc, reqIdx, hsIdx, beatIdx, beatsLeft, ackWait, rdyWait, doneWait;
        int               nDone, nErr, nIrq, ovCount;
        bit               inWait, ovPending, ovNow, doneNow, irqExp;
        bit               expReqNext, expVldNext, expIdleNext, finished;
        logic [31:0]      addrSnap, srcSnap, dstSnap, lenSnap, ctrlSnap;
        logic [5:0][31:0] curW;
        buildModel(head, kind, at);
        cyc = 0; reqIdx = 0; hsIdx = 0; beatIdx = 0; beatsLeft = 0;
        ackWait = -1; rdyWait = -1; doneWait = 0;
        nDone = 0; nErr = 0; nIrq = 0; ovCount = 0;
        inWait = 0; ovPending = 0; irqExp = 0;
        expReqNext = 0; expVldNext = 0; expIdleNext = 0; finished = 0;
        addrSnap = '0; srcSnap = '0; dstSnap = '0; lenSnap = '0; ctrlSnap = '0;
        curW = '0;
        while (!finished && cyc < 600) begin
            @(negedge clk);
            start = 0; ll_ack = 0; ll_dvld = 0; ll_rdata = '0; desc_rdy = 0; xfer_done = 0;
            ovNow = 0; doneNow = 0;
            if (expReqNext) checkOutput("lat_to_req", ll_req, 1);
            if (expVldNext) checkOutput("lat_beat_to_vld", desc_vld, 1);
            if (expIdleNext) begin
                checkOutput("abort_idle_busy", busy, 0);
                checkOutput("abort_no_vld", desc_vld, 0);
            end
            expReqNext = 0; expVldNext = 0; expIdleNext = 0;
            if (cyc == 0) begin
                start = 1;
                head_ptr = head;
                if (head % 4 == 0) expReqNext = 1;
            end else if (!busy) begin
                finished = 1;
            end
            if (!finished) begin
                if (kind == AB_DATA && reqIdx - 1 == at && beatIdx >= 2) abort = 1;
                if (ll_req) begin
                    if (ackWait < 0) begin
                        addrSnap = ll_addr;
                        ackWait = bp ? 5 : int'($urandom_range(0, 2));
                    end else begin
                        checkOutput("addr_stable", ll_addr, addrSnap);
                    end
                    if (ackWait == 0) begin
                        if (reqIdx < expAddr.size()) begin
                            checkOutput("req_addr", ll_addr, expAddr[reqIdx]);
                            curW = mem[expAddr[reqIdx]];
                        end else begin
                            checkOutput("req_count", reqIdx + 1, expAddr.size());
                            curW = '0;
                        end
                        reqIdx++;
                        ll_ack = 1;
                        ackWait = -1;
                        beatsLeft = 6;
                        beatIdx = 0;
                    end else begin
                        ackWait--;
                    end
                end else if (beatsLeft > 0) begin
                    if (extras) xfer_done = 1'($urandom_range(0, 1));
                    if (bp || $urandom_range(0, 3) != 0) begin
                        ll_dvld = 1;
                        ll_rdata = curW[beatIdx];
                        beatIdx++;
                        beatsLeft--;
                        if (beatsLeft == 0) begin
                            if (abort) expIdleNext = 1;
                            else expVldNext = 1;
                        end
                    end
                end else if (desc_vld) begin
                    if (rdyWait < 0) begin
                        srcSnap = desc_src; dstSnap = desc_dst;
                        lenSnap = desc_len; ctrlSnap = desc_ctrl;
                        rdyWait = bp ? 4 : int'($urandom_range(0, 2));
                    end else begin
                        checkOutput("src_stable", desc_src, srcSnap);
                        checkOutput("dst_stable", desc_dst, dstSnap);
                        checkOutput("len_stable", desc_len, lenSnap);
                        checkOutput("ctrl_stable", desc_ctrl, ctrlSnap);
                    end
                    if (kind == AB_ISSUE && hsIdx == at) begin
                        abort = 1;
                        expIdleNext = 1;
                    end else if (rdyWait == 0) begin
                        desc_rdy = 1;
                        checkOutput("desc_src", desc_src, curW[0]);
                        checkOutput("desc_dst", desc_dst, curW[1]);
                        checkOutput("desc_len", desc_len, curW[2]);
                        checkOutput("desc_ctrl", desc_ctrl, curW[4]);
                        if (kind == AB_WAIT && hsIdx == at) abort = 1;
                        if (extras) begin
                            start = 1;
                            head_ptr = 32'h0000_7770;
                            if (hsIdx == 0) ovPending = 1;
                        end
                        hsIdx++;
                        rdyWait = -1;
                        inWait = 1;
                        doneWait = int'($urandom_range(1, 3));
                    end else begin
                        rdyWait--;
                    end
                end else if (inWait) begin
                    if (ovPending) begin
                        ll_dvld = 1;
                        ll_rdata = $urandom;
                        ovNow = 1;
                        ovPending = 0;
                        ovCount++;
                    end else if (doneWait == 0) begin
                        xfer_done = 1;
                        doneNow = 1;
                        irqExp = curW[4][1];
                        inWait = 0;
                        if (reqIdx < expAddr.size()) expReqNext = 1;
                    end else begin
                        doneWait--;
                    end
                end
            end
            #1;
            if (!finished) begin
                checkOutput("irq_pulse", irq, doneNow && irqExp);
                if (ovNow) checkOutput("overrun_err", err, 1);
                nDone += int'(chain_done);
                nErr += int'(err);
                nIrq += int'(irq);
            end
            cyc++;
        end
        if (!finished) checkOutput("timeout_busy", busy, 0);
        start = 0; ll_ack = 0; ll_dvld = 0; desc_rdy = 0; xfer_done = 0; abort = 0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_no_req", ll_req, 0);
        end
        checkOutput("req_count", reqIdx, expAddr.size());
        checkOutput("handshakes", hsIdx, expHs);
        checkOutput("chain_done_count", nDone, expDone);
        checkOutput("err_count", nErr, expErr + ovCount);
        checkOutput("irq_count", nIrq, expIrq);
        checkOutput("end_busy", busy, 0);
    endtask

    initial begin
        int          n, term, kind, at;
        logic [31:0] addrs [4];
        logic [31:0] nxt, ctrl;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_ll_req", ll_req, 0);
        checkOutput("rst_ll_addr", ll_addr, 0);
        checkOutput("rst_desc_vld", desc_vld, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_chain_done", chain_done, 0);
        checkOutput("rst_irq", irq, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_desc_src", desc_src, 0);
        rst = 0;
        @(negedge clk);

        $display("[TB] single descriptor");
        setDesc(32'h1000, 32'hA000, 32'hB000, 32'h40, 32'h0, 32'h1);
        applyStimulus(32'h1000, AB_NONE, 0, 0, 0);

        $display("[TB] three-descriptor chain");
        setDesc(32'h1000, 32'hA000, 32'hB000, 32'h40, 32'h2000, 32'h2);
        setDesc(32'h2000, 32'hA100, 32'hB100, 32'h80, 32'h3000, 32'h0);
        setDesc(32'h3000, 32'hA200, 32'hB200, 32'hC0, 32'h0, 32'h3);
        applyStimulus(32'h1000, AB_NONE, 0, 0, 1);

        $display("[TB] backpressure");
        applyStimulus(32'h1000, AB_NONE, 0, 1, 0);

        $display("[TB] bad pointers");
        setDesc(32'h4000, 32'h1, 32'h2, 32'h3, 32'h0, 32'h0);
        applyStimulus(32'h4000, AB_NONE, 0, 0, 0);
        setDesc(32'h5000, 32'h1, 32'h2, 32'h3, 32'h6002, 32'h2);
        applyStimulus(32'h5000, AB_NONE, 0, 0, 0);
        applyStimulus(32'h1002, AB_NONE, 0, 0, 0);

        $display("[TB] abort");
        applyStimulus(32'h1000, AB_DATA, 1, 0, 0);
        applyStimulus(32'h1000, AB_WAIT, 0, 0, 0);
        applyStimulus(32'h1000, AB_ISSUE, 2, 1, 0);

        $display("[TB] reset mid-DATA");
        @(negedge clk);
        start = 1;
        head_ptr = 32'h1000;
        @(negedge clk);
        start = 0;
        checkOutput("rst_seq_req", ll_req, 1);
        ll_ack = 1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            ll_ack = 0;
            ll_dvld = 1;
            ll_rdata = mem[32'h1000][b];
        end
        @(negedge clk);
        rst = 1;
        #1;
        checkOutput("mid_rst_ll_req", ll_req, 0);
        checkOutput("mid_rst_desc_vld", desc_vld, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_err", err, 0);
        checkOutput("mid_rst_chain_done", chain_done, 0);
        checkOutput("mid_rst_desc_src", desc_src, 0);
        checkOutput("mid_rst_ll_addr", ll_addr, 0);
        @(negedge clk);
        ll_dvld = 0;
        rst = 0;
        applyStimulus(32'h1000, AB_NONE, 0, 0, 0);

        $display("[TB] random chains");
        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(1, 4));
            term = int'($urandom_range(0, 2));
            for (int i = 0; i < 4; i++)
                addrs[i] = 32'h0001_0000 + r * 32'h1000 + i * 32'h100 + $urandom_range(0, 63) * 4;
            for (int i = 0; i < n; i++) begin
                ctrl = {30'd0, 1'($urandom_range(0, 1)), 1'b0};
                nxt = (i < n - 1) ? addrs[i + 1] : 32'h0;
                if (i == n - 1) begin
                    if (term == 0) ctrl[0] = 1'b1;
                    else if (term == 2) nxt = 32'h0002_0002;
                end
                setDesc(addrs[i], $urandom, $urandom, $urandom, nxt, ctrl);
            end
            kind = int'($urandom_range(0, 3));
            at = int'($urandom_range(0, n - 1));
            applyStimulus(addrs[0], kind, at, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
